// File: rtl/sram_controller.sv
// Bridges a 32-bit CPU load/store port to a 16-bit asynchronous SRAM.
// Each access is split into a low half and a high half, each held for WAIT_CYCLES clocks.
module sram_controller #(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE      = 32'(ADDR_BASE);

  state_e      state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic        opWrite_q, opWrite_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] readData_q, readData_d;
  logic [17:0] sramAddr_q, sramAddr_d;
  logic [16:0] word;
  logic        lastWait;
  logic        request;
  logic        dqDrive;
  logic [15:0] dqOut;

  // Addresses below the base wrap silently into the top of the SRAM.
  assign word     = 17'((addr_q - BASE) >> 2);
  assign lastWait = (waitCnt_q == WAIT_LAST);
  assign request  = wr_en | rd_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      waitCnt_q  <= 4'd0;
      opWrite_q  <= 1'b0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      readData_q <= 32'd0;
      sramAddr_q <= 18'd0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      opWrite_q  <= opWrite_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      readData_q <= readData_d;
      sramAddr_q <= sramAddr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    opWrite_d  = opWrite_q;
    addr_d     = addr_q;
    data_d     = data_q;
    readData_d = readData_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          opWrite_d = wr_en;
          addr_d    = address;
          data_d    = write_data;
          waitCnt_d = 4'd0;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (lastWait) begin
          waitCnt_d = 4'd0;
          state_d   = HIGH;
          if (!opWrite_q) readData_d[15:0] = SRAM_DQ;
        end else begin
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (lastWait) begin
          waitCnt_d = 4'd0;
          state_d   = DONE;
          if (!opWrite_q) readData_d[31:16] = SRAM_DQ;
        end else begin
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM_ADDR keeps its last driven value outside the two data phases.
  always_comb begin
    sramAddr_d = sramAddr_q;
    dqDrive    = 1'b0;
    dqOut      = 16'd0;
    case (state_q)
      LOW: begin
        sramAddr_d = {word, 1'b0};
        dqDrive    = opWrite_q;
        dqOut      = data_q[15:0];
      end
      HIGH: begin
        sramAddr_d = {word, 1'b1};
        dqDrive    = opWrite_q;
        dqOut      = data_q[31:16];
      end
      default: ;
    endcase
  end

  assign SRAM_ADDR = sramAddr_d;
  assign SRAM_WE_N = ~dqDrive;
  assign SRAM_DQ   = dqDrive ? dqOut : 16'hzzzz;
  assign read_data = readData_q;
  assign ready     = ~rst | (state_q == DONE) | ((state_q == IDLE) & ~request);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller against a behavioural 16-bit SRAM model.
// Covers reset, write/read-back, address mapping, held requests, conflicts and mid-access reset.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N;

  logic [15:0] mem [0:262143];

  int assertCount = 0;
  int failCount   = 0;

  int          lowCycles;
  int          weLowCycles;
  logic [17:0] addrLow;
  logic [17:0] addrHigh;
  logic [15:0] dqLow;

  sram_controller #(.WAIT_CYCLES(5), .ADDR_BASE(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_WE_N  (SRAM_WE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The SRAM drives the bus whenever the controller is not writing.
  assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR] : 16'hzzzz;

  always @(posedge clk) begin
    if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one request and follows it until ready returns, recording what the bus did.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [31:0] data, input logic changeMid);
    int idx;
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    address = addr;
    write_data = data;
    #1;
    lowCycles = 0;
    weLowCycles = 0;
    addrLow = '0;
    addrHigh = '0;
    dqLow = '0;
    idx = 0;
    while (!ready && idx < 100) begin
      idx++;
      lowCycles++;
      if (!SRAM_WE_N) weLowCycles++;
      if (idx == 2) begin
        addrLow = SRAM_ADDR;
        dqLow = SRAM_DQ;
      end
      if (idx == 7) addrHigh = SRAM_ADDR;
      @(negedge clk);
      if (changeMid && idx == 3) begin
        address = 32'd1100;
        write_data = 32'd0;
      end
      #1;
    end
    if (idx >= 100) checkOutput("accessTimeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic releaseRequest();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b1;
    address = 32'd1024;
    write_data = 32'd0;
    mem[4] <= 16'hBEEF;
    mem[5] <= 16'hCAFE;
    mem[262142] <= 16'h1111;
    mem[262143] <= 16'h2222;
    mem[38] <= 16'h7777;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("resetReady", {31'd0, ready}, 32'd1);
    checkOutput("resetReadData", read_data, 32'd0);
    checkOutput("resetWeN", {31'd0, SRAM_WE_N}, 32'd1);
    checkOutput("resetAddr", {14'd0, SRAM_ADDR}, 32'd0);

    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("idleReady", {31'd0, ready}, 32'd1);

    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h12345678, 1'b0);
    checkOutput("wrReadyLow", lowCycles, 32'd11);
    checkOutput("wrWeLow", weLowCycles, 32'd10);
    checkOutput("wrAddrLow", {14'd0, addrLow}, 32'd0);
    checkOutput("wrAddrHigh", {14'd0, addrHigh}, 32'd1);
    checkOutput("wrDqLow", {16'd0, dqLow}, 32'h5678);
    checkOutput("wrReadData", read_data, 32'd0);
    releaseRequest();
    checkOutput("wrMemLow", {16'd0, mem[0]}, 32'h5678);
    checkOutput("wrMemHigh", {16'd0, mem[1]}, 32'h1234);
    checkOutput("wrIdleReady", {31'd0, ready}, 32'd1);

    applyStimulus(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);
    checkOutput("rdReadyLow", lowCycles, 32'd11);
    checkOutput("rdWeLow", weLowCycles, 32'd0);
    checkOutput("rdDone", read_data, 32'h12345678);
    releaseRequest();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rdPersist", read_data, 32'h12345678);

    applyStimulus(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0);
    checkOutput("map1032Low", {14'd0, addrLow}, 32'd4);
    checkOutput("map1032High", {14'd0, addrHigh}, 32'd5);
    checkOutput("map1032Data", read_data, 32'hCAFEBEEF);
    releaseRequest();

    applyStimulus(1'b0, 1'b1, 32'd1020, 32'd0, 1'b0);
    checkOutput("map1020Low", {14'd0, addrLow}, 32'h3FFFE);
    checkOutput("map1020High", {14'd0, addrHigh}, 32'h3FFFF);
    checkOutput("map1020Data", read_data, 32'h22221111);
    releaseRequest();

    applyStimulus(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);
    checkOutput("heldFirstData", read_data, 32'h12345678);
    applyStimulus(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);
    checkOutput("heldSecondLow", lowCycles, 32'd11);
    checkOutput("heldSecondData", read_data, 32'h12345678);
    releaseRequest();

    applyStimulus(1'b1, 1'b1, 32'd1028, 32'hA5A55A5A, 1'b0);
    checkOutput("conflictWeLow", weLowCycles, 32'd10);
    checkOutput("conflictReadData", read_data, 32'h12345678);
    releaseRequest();
    checkOutput("conflictMemLow", {16'd0, mem[2]}, 32'h5A5A);
    checkOutput("conflictMemHigh", {16'd0, mem[3]}, 32'hA5A5);

    applyStimulus(1'b1, 1'b0, 32'd1040, 32'hDEADBEEF, 1'b1);
    checkOutput("changeAddrHigh", {14'd0, addrHigh}, 32'd9);
    releaseRequest();
    checkOutput("changeMemLow", {16'd0, mem[8]}, 32'hBEEF);
    checkOutput("changeMemHigh", {16'd0, mem[9]}, 32'hDEAD);
    checkOutput("changeUntouched", {16'd0, mem[38]}, 32'h7777);

    @(negedge clk);
    wr_en = 1'b1;
    address = 32'd1048;
    write_data = 32'h11223344;
    repeat (7) @(negedge clk);
    #1;
    checkOutput("midHighWeN", {31'd0, SRAM_WE_N}, 32'd0);
    checkOutput("midHighAddr", {14'd0, SRAM_ADDR}, 32'd13);
    rst = 1'b0;
    #1;
    checkOutput("abortWeN", {31'd0, SRAM_WE_N}, 32'd1);
    checkOutput("abortReady", {31'd0, ready}, 32'd1);
    checkOutput("abortReadData", read_data, 32'd0);
    checkOutput("abortAddr", {14'd0, SRAM_ADDR}, 32'd0);
    checkOutput("abortDqModel", {16'd0, SRAM_DQ}, {16'd0, mem[0]});
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("postResetReady", {31'd0, ready}, 32'd1);
    checkOutput("postResetWeN", {31'd0, SRAM_WE_N}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
